// File: rtl/kyber_pkg.sv
// Shared Kyber constants, the legal coefficient-width check and the byte
// encoder state type.
package kyber_pkg;

    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;
    localparam int MAX_D   = 12;
    localparam int ACC_W   = MAX_D + 8;

    // Widths used by Kyber-768: d_u, d_v and the 12-bit key encoding.
    localparam int D_U  = 10;
    localparam int D_V  = 4;
    localparam int D_PK = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } enc_state_e;

    function automatic logic is_legal_d(input logic [3:0] d);
        return (d != 4'd0) && (d <= 4'(MAX_D));
    endfunction

endpackage

// File: rtl/byte_encoder.sv
// ByteEncode_d packer: takes the low d bits of each coefficient, concatenates
// them LSB-first and emits one polynomial's 32*d bytes over a valid/ready port.
module byte_encoder
    import kyber_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [3:0]  d_i,
    input  logic        coef_valid_i,
    output logic        coef_ready_o,
    input  logic [15:0] coef_i,
    output logic        byte_valid_o,
    input  logic        byte_ready_i,
    output logic [7:0]  byte_o,
    output logic        byte_last_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(ACC_W + 1);
    localparam int CC_W  = $clog2(KYBER_N + 1);

    enc_state_e       r_state, w_state_nxt;
    logic [ACC_W-1:0] r_acc, w_acc_nxt, w_acc_shift, w_mask, w_coef_bits;
    logic [CNT_W-1:0] r_bit_cnt, w_bit_cnt_nxt, w_bit_shift;
    logic [CC_W-1:0]  r_coef_cnt, w_coef_cnt_nxt;
    logic [3:0]       r_d, w_d_nxt;
    logic             r_err, w_err_nxt;
    logic             w_run, w_byte_fire, w_coef_fire;

    // Handshake outputs depend only on registered state, never on the
    // opposite port's valid/ready.
    assign w_run        = (r_state == ST_RUN);
    assign coef_ready_o = w_run && (r_bit_cnt <= CNT_W'(8)) && (r_coef_cnt < CC_W'(KYBER_N));
    assign byte_valid_o = w_run && (r_bit_cnt >= CNT_W'(8));
    assign byte_o       = r_acc[7:0];
    assign byte_last_o  = byte_valid_o && (r_coef_cnt == CC_W'(KYBER_N)) && (r_bit_cnt == CNT_W'(8));
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign err_o        = r_err;

    assign w_byte_fire = byte_valid_o && byte_ready_i;
    assign w_coef_fire = coef_ready_o && coef_valid_i;

    // A same-cycle byte fire drains first so the new coefficient lands at bit_cnt'.
    assign w_acc_shift = w_byte_fire ? (r_acc >> 8) : r_acc;
    assign w_bit_shift = w_byte_fire ? (r_bit_cnt - CNT_W'(8)) : r_bit_cnt;
    assign w_mask      = (ACC_W'(1) << r_d) - ACC_W'(1);
    assign w_coef_bits = ACC_W'(coef_i) & w_mask;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case below can infer a latch.
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_coef_cnt_nxt = r_coef_cnt;
        w_d_nxt        = r_d;
        w_err_nxt      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    if (is_legal_d(d_i)) begin
                        w_d_nxt        = d_i;
                        w_acc_nxt      = '0;
                        w_bit_cnt_nxt  = '0;
                        w_coef_cnt_nxt = '0;
                        w_state_nxt    = ST_RUN;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                w_acc_nxt     = w_acc_shift;
                w_bit_cnt_nxt = w_bit_shift;
                if (w_coef_fire) begin
                    w_acc_nxt      = w_acc_shift | (w_coef_bits << w_bit_shift);
                    w_bit_cnt_nxt  = w_bit_shift + CNT_W'(r_d);
                    w_coef_cnt_nxt = r_coef_cnt + CC_W'(1);
                end
                if (w_byte_fire && byte_last_o) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_bit_cnt  <= '0;
            r_coef_cnt <= '0;
            r_d        <= '0;
            r_err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the same pre-edge values.
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_coef_cnt <= w_coef_cnt_nxt;
            r_d        <= w_d_nxt;
            r_err      <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_byte_encoder.sv
// Self-checking bench for byte_encoder: a bit-stream reference model builds
// the expected bytes for each polynomial and one loop compares every transfer.
module tb_byte_encoder;
    import kyber_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  d_i = '0;
    logic        coef_valid_i = 1'b0;
    logic        coef_ready_o;
    logic [15:0] coef_i = '0;
    logic        byte_valid_o;
    logic        byte_ready_i = 1'b0;
    logic [7:0]  byte_o;
    logic        byte_last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    byte_encoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .d_i          (d_i),
        .coef_valid_i (coef_valid_i),
        .coef_ready_o (coef_ready_o),
        .coef_i       (coef_i),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_o       (byte_o),
        .byte_last_o  (byte_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         coefs[KYBER_N];
    logic [7:0] exp_q[$];
    bit         junk_ones = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_compared++;
        if (act !== req) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Stream bit k is bit (k % d) of coefficient k / d; byte b holds stream bits 8b..8b+7.
    function automatic void build_model(input int d);
        exp_q.delete();
        for (int b = 0; b < 32 * d; b++) begin
            logic [7:0] v;
            v = '0;
            for (int t = 0; t < 8; t++) begin
                int k;
                k = 8 * b + t;
                v[t] = 1'((coefs[k / d] >> (k % d)) & 1);
            end
            exp_q.push_back(v);
        end
    endfunction

    task automatic err_test(input int d);
        @(negedge clk);
        start_i = 1'b1;
        d_i     = 4'(d);
        @(negedge clk);
        start_i = 1'b0;
        check($sformatf("err_pulse_d%0d", d), err_o, 1);
        check($sformatf("err_busy_d%0d", d), busy_o, 0);
        check($sformatf("err_ready_d%0d", d), coef_ready_o, 0);
        @(negedge clk);
        check($sformatf("err_cleared_d%0d", d), err_o, 0);
        check($sformatf("err_still_idle_d%0d", d), busy_o, 0);
    endtask

    // mode 0: both sides always ready; 1: byte_ready toggles; 2: random on both sides.
    task automatic run_poly(input int d, input int mode, input int abort_after);
        int         total;
        int         n_bytes;
        int         n_coef;
        int         cyc;
        logic       prev_stall;
        logic [7:0] prev_byte;
        logic [15:0] junk;

        build_model(d);
        total      = exp_q.size();
        n_bytes    = 0;
        n_coef     = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_byte  = '0;

        @(negedge clk);
        start_i = 1'b1;
        d_i     = 4'(d);
        @(negedge clk);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("coef_ready_first", coef_ready_o, 1);

        while (n_bytes < total && cyc < 5000) begin
            if (abort_after > 0 && n_coef >= abort_after) begin
                rst_n        = 1'b0;
                coef_valid_i = 1'b0;
                byte_ready_i = 1'b0;
                #1;
                check("abort_outputs",
                      {coef_ready_o, byte_valid_o, byte_last_o, busy_o, done_o, err_o, byte_o}, 0);
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check("abort_idle", busy_o, 0);
                return;
            end

            if (prev_stall) begin
                check("stall_valid_held", byte_valid_o, 1);
                check("stall_byte_held", byte_o, prev_byte);
            end
            if (n_coef == KYBER_N) begin
                check("no_ready_after_n", coef_ready_o, 0);
            end

            case (mode)
                0: begin
                    coef_valid_i = (n_coef < KYBER_N);
                    byte_ready_i = 1'b1;
                end
                1: begin
                    coef_valid_i = (n_coef < KYBER_N);
                    byte_ready_i = (cyc % 2 == 0);
                end
                default: begin
                    coef_valid_i = (n_coef < KYBER_N) && ($urandom_range(3) != 0);
                    byte_ready_i = 1'($urandom_range(1));
                end
            endcase
            junk   = junk_ones ? 16'hFFFF : 16'($urandom);
            coef_i = (n_coef < KYBER_N) ? (16'(coefs[n_coef]) | (junk << d)) : junk;

            if (coef_valid_i && coef_ready_o) begin
                n_coef++;
            end
            if (byte_valid_o && byte_ready_i) begin
                check($sformatf("d%0d_byte_%0d", d, n_bytes), byte_o, exp_q[n_bytes]);
                check($sformatf("d%0d_last_%0d", d, n_bytes), byte_last_o, 32'(n_bytes == total - 1));
                n_bytes++;
            end
            prev_stall = byte_valid_o && !byte_ready_i;
            prev_byte  = byte_o;

            @(negedge clk);
            cyc++;
        end

        coef_valid_i = 1'b0;
        byte_ready_i = 1'b0;
        check($sformatf("d%0d_bytes_transferred", d), n_bytes, total);
        check($sformatf("d%0d_coefs_accepted", d), n_coef, KYBER_N);
        check($sformatf("d%0d_done_pulse", d), done_o, 1);
        @(negedge clk);
        check($sformatf("d%0d_done_cleared", d), done_o, 0);
        check($sformatf("d%0d_idle_after_done", d), busy_o, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {coef_ready_o, byte_valid_o, byte_last_o, busy_o, done_o, err_o, byte_o}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        err_test(0);
        err_test(13);

        // d=4 ramp starting at 1
        for (int i = 0; i < KYBER_N; i++) coefs[i] = (i + 1) % 16;
        build_model(4);
        check("pin_d4_size", exp_q.size(), 128);
        check("pin_d4_b0", exp_q[0], 8'h21);
        check("pin_d4_b1", exp_q[1], 8'h43);
        run_poly(4, 0, 0);

        // d=10 with a hand-checked prefix
        for (int i = 0; i < KYBER_N; i++) coefs[i] = int'($urandom_range(1023));
        coefs[0] = 'h3FF;
        coefs[1] = 'h001;
        coefs[2] = 'h000;
        coefs[3] = 'h000;
        build_model(10);
        check("pin_d10_size", exp_q.size(), 320);
        check("pin_d10_b0", exp_q[0], 8'hFF);
        check("pin_d10_b1", exp_q[1], 8'h07);
        check("pin_d10_b2", exp_q[2], 8'h00);
        check("pin_d10_b3", exp_q[3], 8'h00);
        check("pin_d10_b4", exp_q[4], 8'h00);
        run_poly(10, 2, 0);

        // d=12 ramp under toggling backpressure
        for (int i = 0; i < KYBER_N; i++) coefs[i] = i;
        build_model(12);
        check("pin_d12_size", exp_q.size(), 384);
        check("pin_d12_b1", exp_q[1], 8'h10);
        run_poly(12, 1, 0);

        // d=1 with every input bit set
        for (int i = 0; i < KYBER_N; i++) coefs[i] = 1;
        junk_ones = 1'b1;
        build_model(1);
        check("pin_d1_size", exp_q.size(), 32);
        check("pin_d1_b31", exp_q[31], 8'hFF);
        run_poly(1, 0, 0);
        junk_ones = 1'b0;

        // random widths and random handshakes
        repeat (4) begin
            int d;
            d = int'($urandom_range(12, 1));
            for (int i = 0; i < KYBER_N; i++) coefs[i] = int'($urandom_range((1 << d) - 1));
            run_poly(d, 2, 0);
        end

        // abort mid-polynomial, then a clean run at the same width
        for (int i = 0; i < KYBER_N; i++) coefs[i] = int'($urandom_range(2047));
        run_poly(11, 0, 100);
        for (int i = 0; i < KYBER_N; i++) coefs[i] = int'($urandom_range(2047));
        run_poly(11, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
